// File: rtl/nr_dmrs_qpsk_demap.sv
// Hard-decision QPSK demapper for one NR DMRS block: each accepted symbol
// produces its I bit and then its Q bit on a serial output, one bit per cycle.
module nr_dmrs_qpsk_demap #(
  parameter int FP   = 16,
  parameter int NSYM = 144
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic signed [FP/2-1:0] rx_i,
  input  logic signed [FP/2-1:0] rx_q,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   bit_out,
  output logic                   bit_valid,
  output logic [8:0]             bit_idx,
  output logic                   demap_done
);

  localparam int W  = FP / 2;
  localparam int CW = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam logic signed [W-1:0] ZERO = '0;

  typedef enum logic [1:0] {
    DISARMED,
    ACCEPT,
    EMIT_Q
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   sym_cnt_q, sym_cnt_d;
  logic            qhold_q, qhold_d;
  logic            bit_out_q, bit_out_d;
  logic            bit_valid_q, bit_valid_d;
  logic [8:0]      bit_idx_q, bit_idx_d;
  logic            done_q, done_d;

  logic            handshake;
  logic            last_sym;
  logic            i_neg;
  logic            q_neg;
  logic [8:0]      idx_even;

  assign in_ready  = (state_q == ACCEPT);
  assign handshake = in_ready && in_valid;
  assign last_sym  = (sym_cnt_q == CW'(NSYM - 1));
  // A pure sign test: the most-negative sample needs no special handling.
  assign i_neg     = (rx_i < ZERO);
  assign q_neg     = (rx_q < ZERO);
  assign idx_even  = 9'({sym_cnt_q, 1'b0});

  always_comb begin
    state_d     = state_q;
    sym_cnt_d   = sym_cnt_q;
    qhold_d     = qhold_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = 1'b0;
    bit_idx_d   = bit_idx_q;
    done_d      = 1'b0;

    if (start) begin
      // Restart from any state; a pending Q bit is dropped.
      state_d   = ACCEPT;
      sym_cnt_d = '0;
      qhold_d   = 1'b0;
    end else begin
      case (state_q)
        ACCEPT: begin
          if (handshake) begin
            bit_out_d   = i_neg;
            bit_valid_d = 1'b1;
            bit_idx_d   = idx_even;
            qhold_d     = q_neg;
            state_d     = EMIT_Q;
          end
        end
        EMIT_Q: begin
          bit_out_d   = qhold_q;
          bit_valid_d = 1'b1;
          bit_idx_d   = idx_even | 9'd1;
          if (last_sym) begin
            done_d    = 1'b1;
            sym_cnt_d = '0;
            state_d   = DISARMED;
          end else begin
            sym_cnt_d = sym_cnt_q + CW'(1);
            state_d   = ACCEPT;
          end
        end
        default: begin
          state_d = DISARMED;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= DISARMED;
      sym_cnt_q   <= '0;
      qhold_q     <= 1'b0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      bit_idx_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sym_cnt_q   <= sym_cnt_d;
      qhold_q     <= qhold_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      bit_idx_q   <= bit_idx_d;
      done_q      <= done_d;
    end
  end

  assign bit_out    = bit_out_q;
  assign bit_valid  = bit_valid_q;
  assign bit_idx    = bit_idx_q;
  assign demap_done = done_q;

endmodule

// File: tb/tb_nr_dmrs_qpsk_demap.sv
// Self-checking bench for nr_dmrs_qpsk_demap: vector table, directed corner
// sequences and randomized blocks against a symbol-level reference model.
module tb_nr_dmrs_qpsk_demap;

  localparam int FP   = 16;
  localparam int NSYM = 144;
  localparam int W    = FP / 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic signed [W-1:0] rx_i;
  logic signed [W-1:0] rx_q;
  logic                in_valid;
  logic                in_ready;
  logic                bit_out;
  logic                bit_valid;
  logic [8:0]          bit_idx;
  logic                demap_done;

  always #5 clk = ~clk;

  nr_dmrs_qpsk_demap #(.FP(FP), .NSYM(NSYM)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rx_i      (rx_i),
    .rx_q      (rx_q),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .bit_idx   (bit_idx),
    .demap_done(demap_done)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: an armed flag, an optional pending Q decision and a
  // symbol count describe everything the output stream depends on.
  bit mArmed;
  int mPending;
  int mSym;
  bit mOut;
  bit mValid;
  bit mDone;
  int mIdx;

  typedef struct {
    int i;
    int q;
    bit expI;
    bit expQ;
  } vec_t;

  vec_t vecs[$];

  function automatic void modelReset();
    mArmed   = 1'b0;
    mPending = -1;
    mSym     = 0;
    mOut     = 1'b0;
    mValid   = 1'b0;
    mDone    = 1'b0;
    mIdx     = 0;
  endfunction

  function automatic void modelStep();
    int iv;
    int qv;
    iv     = int'(rx_i);
    qv     = int'(rx_q);
    mValid = 1'b0;
    mDone  = 1'b0;
    if (start) begin
      mArmed   = 1'b1;
      mPending = -1;
      mSym     = 0;
    end else if (mPending >= 0) begin
      mOut     = (mPending == 1);
      mValid   = 1'b1;
      mIdx     = 2 * mSym + 1;
      mDone    = (mSym == NSYM - 1);
      mPending = -1;
      mSym     = mSym + 1;
      if (mSym == NSYM) begin
        mArmed = 1'b0;
        mSym   = 0;
      end
    end else if (mArmed && in_valid) begin
      mOut     = (iv < 0);
      mValid   = 1'b1;
      mIdx     = 2 * mSym;
      mPending = (qv < 0) ? 1 : 0;
    end
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic compareAll();
    checkOutput("in_ready", int'(in_ready), int'(mArmed && mPending < 0));
    checkOutput("bit_valid", int'(bit_valid), int'(mValid));
    checkOutput("bit_out", int'(bit_out), int'(mOut));
    checkOutput("bit_idx", int'(bit_idx), mIdx);
    checkOutput("demap_done", int'(demap_done), int'(mDone));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) modelReset();
    else modelStep();
    #1;
    compareAll();
  endtask

  task automatic applyStimulus(input bit v, input bit st);
    in_valid = v;
    start    = st;
    rx_i     = W'($urandom());
    rx_q     = W'($urandom());
  endtask

  // Asserts reset mid-cycle, checks the immediate effect, releases after 2 edges.
  task automatic asyncReset();
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    compareAll();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Runs one block from a start pulse until the model sees demap_done.
  task automatic runBlock(input string tag, input bit randValid, input bit allowRestart);
    int  seenBits;
    int  seenDone;
    bit  restarted;
    bit  finished;
    seenBits  = 0;
    seenDone  = 0;
    restarted = 1'b0;
    finished  = 1'b0;
    applyStimulus(1'b0, 1'b1);
    tick();
    for (int c = 0; c < 3000 && !finished; c++) begin
      bit st;
      st = allowRestart && ($urandom_range(0, 299) == 0);
      if (st) begin
        restarted = 1'b1;
        seenBits  = 0;
      end
      applyStimulus(randValid ? ($urandom_range(0, 3) != 0) : 1'b1, st);
      if (!randValid) begin
        rx_i = $urandom_range(0, 1) ? W'(64) : W'(-64);
        rx_q = $urandom_range(0, 1) ? W'(64) : W'(-64);
      end
      tick();
      if (bit_valid) seenBits++;
      if (demap_done) seenDone++;
      if (mDone) finished = 1'b1;
    end
    checkOutput({tag, "_finished"}, int'(finished), 1);
    checkOutput({tag, "_doneCount"}, seenDone, 1);
    if (!restarted) checkOutput({tag, "_bitCount"}, seenBits, 2 * NSYM);
    applyStimulus(1'b1, 1'b0);
    tick();
    checkOutput({tag, "_readyAfter"}, int'(in_ready), 0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    rx_i     = '0;
    rx_q     = '0;
    modelReset();
    #1;
    compareAll();
    tick();
    tick();
    rst = 1'b0;

    // Sign-decision vectors, including zero and the most-negative value.
    vecs.push_back('{0, -128, 1'b0, 1'b1});
    vecs.push_back('{-128, 0, 1'b1, 1'b0});
    vecs.push_back('{127, -1, 1'b0, 1'b1});
    vecs.push_back('{-1, 127, 1'b1, 1'b0});
    vecs.push_back('{1, 1, 1'b0, 1'b0});
    vecs.push_back('{-64, -64, 1'b1, 1'b1});

    // Start in the first cycle after reset release.
    applyStimulus(1'b0, 1'b1);
    tick();
    start = 1'b0;
    for (int k = 0; k < vecs.size(); k++) begin
      in_valid = 1'b1;
      rx_i     = W'(vecs[k].i);
      rx_q     = W'(vecs[k].q);
      tick();
      checkOutput("vecI", int'(bit_out), int'(vecs[k].expI));
      checkOutput("vecIdxI", int'(bit_idx), 2 * k);
      in_valid = 1'b0;
      tick();
      checkOutput("vecQ", int'(bit_out), int'(vecs[k].expQ));
      checkOutput("vecIdxQ", int'(bit_idx), 2 * k + 1);
    end

    // in_valid pattern 1,0,0,1 while accepting.
    begin
      bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      applyStimulus(1'b0, 1'b1);
      tick();
      for (int k = 0; k < 4; k++) begin
        applyStimulus(pat[k], 1'b0);
        tick();
        if (mPending >= 0) begin
          applyStimulus(1'b0, 1'b0);
          tick();
        end
      end
      checkOutput("gapIdx", int'(bit_idx), 3);
    end

    // Restart while the Q bit of symbol 10 is pending.
    begin
      bit reached;
      reached = 1'b0;
      applyStimulus(1'b0, 1'b1);
      tick();
      for (int c = 0; c < 100 && !reached; c++) begin
        applyStimulus(1'b1, 1'b0);
        tick();
        if (mValid && mIdx == 20) reached = 1'b1;
      end
      checkOutput("reachSym10", int'(reached), 1);
      applyStimulus(1'b1, 1'b1);
      tick();
      checkOutput("restartNoValid", int'(bit_valid), 0);
      applyStimulus(1'b1, 1'b0);
      tick();
      checkOutput("restartValid", int'(bit_valid), 1);
      checkOutput("restartIdx", int'(bit_idx), 0);
    end

    // in_valid while disarmed consumes nothing.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, 1'b0);
      tick();
      checkOutput("disarmedNoBit", int'(bit_valid), 0);
    end

    runBlock("full", 1'b0, 1'b0);

    // Reset in the middle of a block, then in_valid without start.
    applyStimulus(1'b0, 1'b1);
    tick();
    for (int c = 0; c < 400 && !(mValid && mIdx >= 100); c++) begin
      applyStimulus(1'b1, 1'b0);
      tick();
    end
    checkOutput("reachSym50", int'(mIdx >= 100), 1);
    asyncReset();
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b1, 1'b0);
      tick();
      checkOutput("postRstReady", int'(in_ready), 0);
      checkOutput("postRstValid", int'(bit_valid), 0);
    end
    runBlock("afterRst", 1'b0, 1'b0);

    for (int r = 0; r < 3; r++) runBlock("rand", 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
